// File: rtl/dbi_tx_cmd_sequencer.sv
// dbi_tx_cmd_sequencer
//   DBI TX command/pixel sequencer. Runs the display init once (SOFT_RST,
//   delay, DISP_ON), then per frame sends the column/row windows, optional
//   MADCTL and MEMORY WRITE, followed by FRAME_PIX_NUM pixels split into
//   bytes MSB first. The output is a registered {dcx, byte} valid/ready
//   stream.
//   Optional feature macro: DBI_TX_MADCTL_EN (adds the per-frame MADCTL
//   command and its parameter between SET_ROW and MEM_WR).
module dbi_tx_cmd_sequencer #(
    parameter int DATA_W        = 8,
    parameter int PIXEL_W       = 16,
    parameter int FRAME_PIX_NUM = 76800,
    parameter int PIX_CNT_W     = 17,
    parameter int RST_DLY_CYC   = 5000,
    parameter int DLY_CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dbi_tx_start_i,
    input  logic [DATA_W-1:0]  addr_soft_rst_i,
    input  logic [DATA_W-1:0]  addr_disp_on_i,
    input  logic [DATA_W-1:0]  addr_col_i,
    input  logic [DATA_W-1:0]  addr_row_i,
    input  logic [DATA_W-1:0]  addr_acs_ctrl_i,
    input  logic [DATA_W-1:0]  addr_mem_wr_i,
    input  logic [DATA_W-1:0]  cmd_s_col_h_i,
    input  logic [DATA_W-1:0]  cmd_s_col_l_i,
    input  logic [DATA_W-1:0]  cmd_e_col_h_i,
    input  logic [DATA_W-1:0]  cmd_e_col_l_i,
    input  logic [DATA_W-1:0]  cmd_s_row_h_i,
    input  logic [DATA_W-1:0]  cmd_s_row_l_i,
    input  logic [DATA_W-1:0]  cmd_e_row_h_i,
    input  logic [DATA_W-1:0]  cmd_e_row_l_i,
    input  logic [DATA_W-1:0]  cmd_acs_ctrl_i,
    input  logic [PIXEL_W-1:0] pxl_data_i,
    input  logic               pxl_vld_i,
    output logic               pxl_rdy_o,
    output logic [DATA_W-1:0]  dbi_data_o,
    output logic               dbi_dcx_o,
    output logic               dbi_vld_o,
    input  logic               dbi_rdy_i,
    output logic               busy_o,
    output logic               frame_done_o
);
    localparam int NB   = PIXEL_W / DATA_W;
    localparam int PB_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_SOFT_RST, S_RST_WAIT, S_DISP_ON, S_SET_COL, S_SET_ROW,
`ifdef DBI_TX_MADCTL_EN
        S_MADCTL,
`endif
        S_MEM_WR, S_PIXEL, S_DONE
    } state_t;

    state_t                      r_st, w_nxt_st, w_follow;
    logic [2:0]                  r_idx, w_nxt_idx, w_last_idx;
    logic                        r_vld, r_dcx, r_init_done;
    logic [DATA_W-1:0]           r_data, w_follow_op, w_pix_byte;
    logic [DLY_CNT_W-1:0]        r_dly_cnt;
    logic [DATA_W-1:0]           r_op_disp_on, r_op_col, r_op_row, r_op_mem_wr;
    logic [3:0][DATA_W-1:0]      r_col, r_row;
    logic [PIXEL_W-1:0]          r_pix;
    logic                        r_pix_full, r_pix_all;
    logic [PB_W-1:0]             r_pidx;
    logic [PIX_CNT_W-1:0]        r_pix_cnt;
    logic                        w_free, w_acc, w_pxl_acc;
    logic                        w_ld, w_drop, w_snap, w_set_init;
    logic                        w_pix_ld_hold, w_pix_ld_byp;
    logic [DATA_W:0]             w_ld_byte, w_param_byte;
`ifdef DBI_TX_MADCTL_EN
    logic [DATA_W-1:0]           r_op_acs, r_prm_acs;
`else
    logic                        w_unused_acs;
    assign w_unused_acs = &{1'b0, addr_acs_ctrl_i, cmd_acs_ctrl_i};
`endif

    assign w_free       = ~r_vld | dbi_rdy_i;
    assign w_acc        = r_vld & dbi_rdy_i;
    assign pxl_rdy_o    = (r_st == S_PIXEL) & ~r_pix_full & ~r_pix_all;
    assign w_pxl_acc    = pxl_vld_i & pxl_rdy_o;
    assign w_pix_byte   = DATA_W'(r_pix >> {PB_W'(NB - 1) - r_pidx, 3'b000});
    assign dbi_data_o   = r_data;
    assign dbi_dcx_o    = r_dcx;
    assign dbi_vld_o    = r_vld;
    assign busy_o       = (r_st != S_IDLE);
    assign frame_done_o = (r_st == S_DONE);

    // Command phase table: last byte index, successor phase, its opcode, next param byte
    always_comb begin
        w_last_idx   = 3'd0;
        w_follow     = S_IDLE;
        w_param_byte = {1'b1, r_col[r_idx[1:0]]};
        case (r_st)
            S_SOFT_RST: w_follow = S_RST_WAIT;
            S_DISP_ON:  w_follow = S_SET_COL;
            S_SET_COL:  begin w_last_idx = 3'd4; w_follow = S_SET_ROW; end
            S_SET_ROW: begin
                w_last_idx   = 3'd4;
                w_param_byte = {1'b1, r_row[r_idx[1:0]]};
`ifdef DBI_TX_MADCTL_EN
                w_follow     = S_MADCTL;
`else
                w_follow     = S_MEM_WR;
`endif
            end
`ifdef DBI_TX_MADCTL_EN
            S_MADCTL: begin
                w_last_idx   = 3'd1;
                w_follow     = S_MEM_WR;
                w_param_byte = {1'b1, r_prm_acs};
            end
`endif
            S_MEM_WR:   w_follow = S_PIXEL;
            default:    ;
        endcase
        case (w_follow)
            S_SET_COL: w_follow_op = r_op_col;
            S_SET_ROW: w_follow_op = r_op_row;
`ifdef DBI_TX_MADCTL_EN
            S_MADCTL:  w_follow_op = r_op_acs;
`endif
            S_MEM_WR:  w_follow_op = r_op_mem_wr;
            default:   w_follow_op = '0;
        endcase
    end

    // Next state and output-byte load decisions; a new byte loads on the cycle the old one is taken
    always_comb begin
        w_nxt_st      = r_st;
        w_nxt_idx     = r_idx;
        w_ld          = 1'b0;
        w_ld_byte     = '0;
        w_drop        = 1'b0;
        w_snap        = 1'b0;
        w_set_init    = 1'b0;
        w_pix_ld_hold = 1'b0;
        w_pix_ld_byp  = 1'b0;
        case (r_st)
            S_IDLE: if (dbi_tx_start_i) begin
                w_snap    = 1'b1;
                w_ld      = 1'b1;
                w_nxt_idx = '0;
                if (r_init_done) begin
                    w_nxt_st  = S_SET_COL;
                    w_ld_byte = {1'b0, addr_col_i};
                end else begin
                    w_nxt_st  = S_SOFT_RST;
                    w_ld_byte = {1'b0, addr_soft_rst_i};
                end
            end
            S_RST_WAIT: if (r_dly_cnt == DLY_CNT_W'(RST_DLY_CYC - 1)) begin
                w_nxt_st   = S_DISP_ON;
                w_ld       = 1'b1;
                w_ld_byte  = {1'b0, r_op_disp_on};
                w_set_init = 1'b1;
            end
            S_PIXEL: if (w_free) begin
                if (r_pix_full) begin
                    w_ld          = 1'b1;
                    w_pix_ld_hold = 1'b1;
                    w_ld_byte     = {1'b1, w_pix_byte};
                end else if (w_pxl_acc) begin
                    // MSB byte goes straight out so a new pixel costs no bubble
                    w_ld         = 1'b1;
                    w_pix_ld_byp = 1'b1;
                    w_ld_byte    = {1'b1, pxl_data_i[PIXEL_W-1 -: DATA_W]};
                end else begin
                    w_drop = 1'b1;
                    if (r_pix_all && r_vld)
                        w_nxt_st = S_DONE;
                end
            end
            S_DONE: w_nxt_st = S_IDLE;
            default: if (w_acc) begin
                if (r_idx == w_last_idx) begin
                    w_nxt_st  = w_follow;
                    w_nxt_idx = '0;
                    if (w_follow == S_RST_WAIT || w_follow == S_PIXEL) begin
                        w_drop = 1'b1;
                    end else begin
                        w_ld      = 1'b1;
                        w_ld_byte = {1'b0, w_follow_op};
                    end
                end else begin
                    w_nxt_idx = r_idx + 3'd1;
                    w_ld      = 1'b1;
                    w_ld_byte = w_param_byte;
                end
            end
        endcase
    end

    // State and byte-index register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st  <= S_IDLE;
            r_idx <= '0;
        end else begin
            r_st  <= w_nxt_st;
            r_idx <= w_nxt_idx;
        end
    end

    // Output byte register; holds while valid and not ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_dcx  <= 1'b0;
            r_data <= '0;
        end else if (w_ld) begin
            r_vld  <= 1'b1;
            r_dcx  <= w_ld_byte[DATA_W];
            r_data <= w_ld_byte[DATA_W-1:0];
        end else if (w_drop) begin
            r_vld  <= 1'b0;
        end
    end

    // Init-done flag and post-SOFT_RST delay counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_done <= 1'b0;
            r_dly_cnt   <= '0;
        end else begin
            if (w_set_init)
                r_init_done <= 1'b1;
            r_dly_cnt <= (r_st == S_RST_WAIT) ? r_dly_cnt + DLY_CNT_W'(1) : '0;
        end
    end

    // Snapshot of opcode/param inputs when a frame starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_disp_on <= '0;
            r_op_col     <= '0;
            r_op_row     <= '0;
            r_op_mem_wr  <= '0;
            r_col        <= '0;
            r_row        <= '0;
`ifdef DBI_TX_MADCTL_EN
            r_op_acs     <= '0;
            r_prm_acs    <= '0;
`endif
        end else if (w_snap) begin
            r_op_disp_on <= addr_disp_on_i;
            r_op_col     <= addr_col_i;
            r_op_row     <= addr_row_i;
            r_op_mem_wr  <= addr_mem_wr_i;
            r_col        <= {cmd_e_col_l_i, cmd_e_col_h_i, cmd_s_col_l_i, cmd_s_col_h_i};
            r_row        <= {cmd_e_row_l_i, cmd_e_row_h_i, cmd_s_row_l_i, cmd_s_row_h_i};
`ifdef DBI_TX_MADCTL_EN
            r_op_acs     <= addr_acs_ctrl_i;
            r_prm_acs    <= cmd_acs_ctrl_i;
`endif
        end
    end

    // Pixel holding register, byte index and per-frame pixel count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix      <= '0;
            r_pix_full <= 1'b0;
            r_pidx     <= '0;
            r_pix_cnt  <= '0;
            r_pix_all  <= 1'b0;
        end else begin
            if (w_pxl_acc) begin
                r_pix <= pxl_data_i;
                if (w_pix_ld_byp) begin
                    r_pix_full <= (NB > 1);
                    r_pidx     <= PB_W'(1);
                end else begin
                    r_pix_full <= 1'b1;
                    r_pidx     <= '0;
                end
                if (r_pix_cnt == PIX_CNT_W'(FRAME_PIX_NUM - 1)) begin
                    r_pix_cnt <= '0;
                    r_pix_all <= 1'b1;
                end else begin
                    r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);
                end
            end else if (w_pix_ld_hold) begin
                if (r_pidx == PB_W'(NB - 1)) begin
                    r_pix_full <= 1'b0;
                    r_pidx     <= '0;
                end else begin
                    r_pidx <= r_pidx + PB_W'(1);
                end
            end
            if (r_st == S_DONE)
                r_pix_all <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dbi_tx_cmd_sequencer.sv
// tb_dbi_tx_cmd_sequencer
//   Directed bench: init + three frames (second with a mid-frame param
//   write, third under random backpressure and pixel stalls), then a
//   reset during SET_ROW and an init re-run.
`timescale 1ns/1ps
module tb_dbi_tx_cmd_sequencer;
    localparam int N   = 4;
    localparam int DLY = 10;

    logic        clk = 1'b0, rst = 1'b0;
    logic        dbi_tx_start_i = 1'b0;
    logic [7:0]  addr_soft_rst_i = 8'h01, addr_disp_on_i = 8'h29, addr_col_i = 8'h2A;
    logic [7:0]  addr_row_i = 8'h2B, addr_acs_ctrl_i = 8'h36, addr_mem_wr_i = 8'h2C;
    logic [7:0]  cmd_s_col_h_i = 8'h00, cmd_s_col_l_i = 8'h00, cmd_e_col_h_i = 8'h00, cmd_e_col_l_i = 8'hEF;
    logic [7:0]  cmd_s_row_h_i = 8'h00, cmd_s_row_l_i = 8'h00, cmd_e_row_h_i = 8'h01, cmd_e_row_l_i = 8'h3F;
    logic [7:0]  cmd_acs_ctrl_i = 8'h08;
    logic [15:0] pxl_data_i = '0;
    logic        pxl_vld_i = 1'b0, pxl_rdy_o;
    logic [7:0]  dbi_data_o;
    logic        dbi_dcx_o, dbi_vld_o, dbi_rdy_i = 1'b1, busy_o, frame_done_o;

    dbi_tx_cmd_sequencer #(.DATA_W(8), .PIXEL_W(16), .FRAME_PIX_NUM(N), .PIX_CNT_W(3),
                           .RST_DLY_CYC(DLY), .DLY_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .dbi_tx_start_i(dbi_tx_start_i),
        .addr_soft_rst_i(addr_soft_rst_i), .addr_disp_on_i(addr_disp_on_i),
        .addr_col_i(addr_col_i), .addr_row_i(addr_row_i),
        .addr_acs_ctrl_i(addr_acs_ctrl_i), .addr_mem_wr_i(addr_mem_wr_i),
        .cmd_s_col_h_i(cmd_s_col_h_i), .cmd_s_col_l_i(cmd_s_col_l_i),
        .cmd_e_col_h_i(cmd_e_col_h_i), .cmd_e_col_l_i(cmd_e_col_l_i),
        .cmd_s_row_h_i(cmd_s_row_h_i), .cmd_s_row_l_i(cmd_s_row_l_i),
        .cmd_e_row_h_i(cmd_e_row_h_i), .cmd_e_row_l_i(cmd_e_row_l_i),
        .cmd_acs_ctrl_i(cmd_acs_ctrl_i),
        .pxl_data_i(pxl_data_i), .pxl_vld_i(pxl_vld_i), .pxl_rdy_o(pxl_rdy_o),
        .dbi_data_o(dbi_data_o), .dbi_dcx_o(dbi_dcx_o), .dbi_vld_o(dbi_vld_o),
        .dbi_rdy_i(dbi_rdy_i), .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0, done_cnt = 0, px_idx = 0, bad_rdy = 0, rd = 0;
    bit px_en = 1'b0, bp_en = 1'b0;
    logic [8:0] got_q[$], exp_q[$];
    int         got_t[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] px_val(input int k);
        logic [7:0] kb;
        kb = k[7:0];
        if (k == 0) return 16'hF81F;
        if (k == 1) return 16'h07E0;
        return {kb * 8'd37 + 8'd3, kb ^ 8'h5A};
    endfunction

    // Expected byte list for one frame
    task automatic build_frame(input bit init, input logic [7:0] scl, input int pb);
        logic [15:0] p;
        if (init) begin
            exp_q.push_back({1'b0, 8'h01});
            exp_q.push_back({1'b0, 8'h29});
        end
        exp_q.push_back({1'b0, 8'h2A}); exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, scl});   exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'hEF});
        exp_q.push_back({1'b0, 8'h2B}); exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'h01});
        exp_q.push_back({1'b1, 8'h3F});
`ifdef DBI_TX_MADCTL_EN
        exp_q.push_back({1'b0, 8'h36}); exp_q.push_back({1'b1, 8'h08});
`endif
        exp_q.push_back({1'b0, 8'h2C});
        for (int k = 0; k < N; k++) begin
            p = px_val(pb + k);
            exp_q.push_back({1'b1, p[15:8]});
            exp_q.push_back({1'b1, p[7:0]});
        end
    endtask

    task automatic cmp_new(input string tag);
        while (rd < exp_q.size()) begin
            if (rd < got_q.size()) chk(tag, got_q[rd], exp_q[rd]);
            else                   chk({tag, "_missing"}, 32'd0, 32'd1);
            rd++;
        end
    endtask

    task automatic wait_done(input int k, input int lim);
        int n;
        n = 0;
        while (done_cnt < k && n < lim) begin @(negedge clk); n++; end
        chk("frame_done_seen", 32'(done_cnt >= k), 32'd1);
    endtask

    task automatic wait_bytes(input int k, input int lim);
        int n;
        n = 0;
        while (got_q.size() < k && n < lim) begin @(negedge clk); n++; end
        chk("bytes_arrived", 32'(got_q.size() >= k), 32'd1);
    endtask

    // Output monitor: accepted bytes, hold stability, pixel accepts, done pulses
    initial begin
        logic       p_stall;
        logic [8:0] p_byte;
        p_stall = 1'b0;
        p_byte  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (p_stall) begin
                    chk("hold_vld", 32'(dbi_vld_o), 32'd1);
                    chk("hold_byte", 32'({dbi_dcx_o, dbi_data_o}), 32'(p_byte));
                end
                if (dbi_vld_o && dbi_rdy_i) begin
                    got_q.push_back({dbi_dcx_o, dbi_data_o});
                    got_t.push_back(cyc);
                end
                if (pxl_vld_i && pxl_rdy_o) px_idx++;
                if (frame_done_o) done_cnt++;
                if (pxl_rdy_o && !busy_o) bad_rdy++;
            end
            p_stall = !rst && dbi_vld_o && !dbi_rdy_i;
            p_byte  = {dbi_dcx_o, dbi_data_o};
        end
    end

    // Serializer ready and pixel source, driven just after the rising edge
    initial begin
        forever begin
            @(posedge clk); #1;
            dbi_rdy_i  = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
            pxl_vld_i  = px_en && (!bp_en || $urandom_range(0, 99) >= 30);
            pxl_data_i = px_val(px_idx);
        end
    end

    initial begin
        int n;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rst_vld",   32'(dbi_vld_o), 32'd0);
        chk("rst_data",  32'(dbi_data_o), 32'd0);
        chk("rst_dcx",   32'(dbi_dcx_o), 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_done",  32'(frame_done_o), 32'd0);
        chk("rst_pxrdy", 32'(pxl_rdy_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy_o), 32'd0);

        // Frame 1: init sequence then the frame
        px_en = 1'b1;
        dbi_tx_start_i = 1'b1;
        build_frame(1'b1, 8'h00, 0);
        wait_done(1, 500);
        cmp_new("f1_byte");
        if (got_t.size() >= 2) chk("rst_wait_gap", 32'(got_t[1] - got_t[0]), 32'(DLY + 1));
        else                   chk("rst_wait_gap_bytes", 32'(got_t.size()), 32'd2);
        chk("f1_pixels", 32'(px_idx), 32'(N));

        // Frame 2: start held; param write while its pixels flow
        build_frame(1'b0, 8'h00, N);
        n = 0;
        while (px_idx < N + 1 && n < 500) begin @(posedge clk); #1; n++; end
        chk("f2_pixel_seen", 32'(px_idx >= N + 1), 32'd1);
        cmd_s_col_l_i = 8'h10;
        bp_en = 1'b1;
        wait_done(2, 1000);
        cmp_new("f2_byte");

        // Frame 3: new column start, backpressure, start dropped mid-frame
        build_frame(1'b0, 8'h10, 2 * N);
        repeat (4) @(posedge clk); #1;
        dbi_tx_start_i = 1'b0;
        wait_done(3, 2000);
        cmp_new("f3_byte");
        bp_en = 1'b0;
        repeat (20) @(posedge clk); #1;
        chk("stop_idle", 32'(busy_o), 32'd0);
        chk("byte_total", 32'(got_q.size()), 32'(exp_q.size()));
        chk("pix_total", 32'(px_idx), 32'(3 * N));
        chk("pxrdy_outside_frame", 32'(bad_rdy), 32'd0);

        // Restart skips init; reset during SET_ROW aborts and re-arms init
        got_q.delete(); got_t.delete();
        dbi_tx_start_i = 1'b1;
        wait_bytes(7, 200);
        if (got_q.size() >= 7) begin
            chk("rerun_first", 32'(got_q[0]), 32'h02A);
            chk("rerun_row_cmd", 32'(got_q[5]), 32'h02B);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_vld",  32'(dbi_vld_o), 32'd0);
        chk("abort_data", 32'(dbi_data_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        got_q.delete(); got_t.delete();
        rst = 1'b0;
        wait_bytes(2, 200);
        if (got_q.size() >= 2) begin
            chk("reinit_first", 32'(got_q[0]), 32'h001);
            chk("reinit_second", 32'(got_q[1]), 32'h029);
            chk("reinit_gap", 32'(got_t[1] - got_t[0]), 32'(DLY + 1));
        end
        dbi_tx_start_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
